// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle wide adder driving one external 4-bit carry-lookahead slice.
// Define CLA_SEQ_OVERFLOW_EN to add the two's-complement overflow output V.
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout,
  output logic [3:0]             slice_A,
  output logic [3:0]             slice_B,
  output logic                   slice_Cin,
  input  logic [3:0]             slice_Sum,
  input  logic                   slice_Cout
`ifdef CLA_SEQ_OVERFLOW_EN
  ,
  output logic                   V
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            last;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  assign last = (idx_q == IW'(NIBBLES - 1));
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice inputs are forced low outside RUN so the adder sees a quiet bus.
  always_comb begin
    slice_A   = 4'h0;
    slice_B   = 4'h0;
    slice_Cin = 1'b0;
    if (state_q == RUN) begin
      slice_A   = a_q[idx_q*4 +: 4];
      slice_B   = b_q[idx_q*4 +: 4];
      slice_Cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
      V       <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      carry_q <= Cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      Sum[idx_q*4 +: 4] <= slice_Sum;
      carry_q           <= slice_Cout;
      if (last) begin
        Cout <= slice_Cout;
`ifdef CLA_SEQ_OVERFLOW_EN
        V    <= (a_q[W-1] == b_q[W-1]) && (slice_Sum[3] != a_q[W-1]);
`endif
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer (NIBBLES=4 and NIBBLES=1).
// Behavioural 4-bit adders stand in for the external slices.
module tb_cla_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] sum;
  logic [3:0]  s_a, s_b, s_sum;
  logic        s_cin, s_cout;

  logic        start1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  t_a, t_b, t_sum;
  logic        t_cin, t_cout;

`ifdef CLA_SEQ_OVERFLOW_EN
  logic v, v1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {s_cout, s_sum} = {1'b0, s_a} + {1'b0, s_b} + {4'h0, s_cin};
  assign {t_cout, t_sum} = {1'b0, t_a} + {1'b0, t_b} + {4'h0, t_cin};

  cla_nibble_sequencer #(.NIBBLES(4)) u4 (
    .clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout),
    .slice_A(s_a), .slice_B(s_b), .slice_Cin(s_cin),
    .slice_Sum(s_sum), .slice_Cout(s_cout)
`ifdef CLA_SEQ_OVERFLOW_EN
    , .V(v)
`endif
  );

  cla_nibble_sequencer #(.NIBBLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1),
    .slice_A(t_a), .slice_B(t_b), .slice_Cin(t_cin),
    .slice_Sum(t_sum), .slice_Cout(t_cout)
`ifdef CLA_SEQ_OVERFLOW_EN
    , .V(v1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pulses;
    logic [3:0] cin_seq;
    rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_slice_a", s_a, 0);
    rst = 1'b0;
    step();

    // FFFF + 0001
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_busy", busy, 1);
      chk("t1_nodone", done, 0);
      step();
    end
    chk("t1_busy_off", busy, 0);
    chk("t1_done", done, 1);
    chk("t1_sum", sum, 16'h0000);
    chk("t1_cout", cout, 1);
    step();
    chk("t1_done_fall", done, 0);

    // 1234 + 4321 + 1, carry chain 1,0,0,0
    a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cin_seq = 4'b0001;
    chk("t2_slice_a0", s_a, 4'h4);
    chk("t2_slice_b0", s_b, 4'h1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_slice_cin", s_cin, cin_seq[k]);
      step();
    end
    chk("t2_done", done, 1);
    chk("t2_sum", sum, 16'h5556);
    chk("t2_cout", cout, 0);
    step();
    chk("t2_idle_slice_a", s_a, 0);

    // back-to-back: 0001+0002 then 8000+8000
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("t3_done1", done, 1);
    chk("t3_sum1", sum, 16'h0003);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("t3_gap", n, 5);
    chk("t3_sum2", sum, 16'h0000);
    chk("t3_cout2", cout, 1);
`ifdef CLA_SEQ_OVERFLOW_EN
    chk("t3_v", v, 1);
`endif
    step();

    // start during RUN is ignored
    a = 16'h0011; b = 16'h0022; cin = 1'b0; start = 1'b1;
    step();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) pulses++;
      step();
    end
    chk("t4_pulses", pulses, 1);
    chk("t4_sum", sum, 16'h0033);
    chk("t4_cout", cout, 0);

    // async reset at E2
    a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_sum", sum, 0);
    chk("t5_cout", cout, 0);
    chk("t5_slice_a", s_a, 0);
    chk("t5_slice_cin", s_cin, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) pulses++;
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done) pulses++;
      step();
    end
    chk("t5_no_done", pulses, 0);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("t5_done_after", done, 1);
    chk("t5_sum_after", sum, 16'h0100);
    chk("t5_cout_after", cout, 0);

    // NIBBLES=1: F + F + 1
    a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t6_busy", busy1, 1);
    step();
    chk("t6_done", done1, 1);
    chk("t6_sum", sum1, 4'hF);
    chk("t6_cout", cout1, 1);
`ifdef CLA_SEQ_OVERFLOW_EN
    chk("t6_v", v1, 0);
`endif
    step();
    chk("t6_done_fall", done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
